// File: rtl/moore_step_ctrl.sv
// moore_step_ctrl: command sequencer that loads, steps and counts a Moore machine under test.
// Golden next-state/output checking is built only when MOORE_CHECK_EN is defined.
`timescale 1ns/1ps
module moore_step_ctrl #(
    parameter int ST_W  = 3,
    parameter int SW_W  = 2,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_W-1:0]     cmd_arg,
    input  logic                 stim_valid,
    output logic                 stim_ready,
    input  logic [SW_W-1:0]      stim_data,
    output logic                 dut_reset,
    output logic [ST_W-1:0]      dut_state_in,
    output logic                 dut_ctrl,
    output logic [SW_W-1:0]      dut_sw,
    input  logic [ST_W-1:0]      dut_state,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     steps_done,
    output logic                 underrun,
    input  logic                 cfg_we,
    input  logic [ST_W+SW_W-1:0] cfg_addr,
    input  logic [ST_W-1:0]      cfg_next,
    input  logic                 cfg_out,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     mismatch_step
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LWAIT,
        S_FETCH,
        S_STEP,
        S_SETTLE,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] steps;
    logic [ST_W-1:0]  init_st;
    logic [SW_W-1:0]  sw_q;
    logic             underrun_q;

    logic [SW_W-1:0]  mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             accept;
    logic             fetch_done;

    // Extra pointer bit distinguishes full from empty when indices meet
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign accept     = cmd_valid && cmd_ready;
    assign fetch_done = (steps == target);
    assign push       = stim_valid && !full;
    assign pop        = (state == S_FETCH) && !fetch_done && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        2'b00: state_nx = S_LOAD;
                        2'b01: state_nx = S_FETCH;
                        2'b10: state_nx = (cmd_arg == '0) ? S_FIN
                                                          : S_FETCH;
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOAD:   state_nx = S_LWAIT;
            S_LWAIT:  state_nx = S_FIN;
            S_FETCH:  state_nx = (fetch_done || empty) ? S_FIN : S_STEP;
            S_STEP:   state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_FETCH;
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        done         = (state == S_FIN);
        dut_reset    = (state == S_LOAD);
        dut_ctrl     = (state == S_STEP);
        dut_state_in = (state == S_LOAD) ? init_st : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= stim_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            target     <= '0;
            steps      <= '0;
            init_st    <= '0;
            sw_q       <= '0;
            underrun_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                sw_q   <= mem[rd_ptr[AW-1:0]];
            end
            if (accept) begin
                unique case (cmd_op)
                    2'b00: init_st <= cmd_arg[ST_W-1:0];
                    2'b01: begin
                        target <= CNT_W'(1);
                        steps  <= '0;
                    end
                    2'b10: begin
                        target <= cmd_arg;
                        steps  <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == S_LOAD) begin
                steps      <= '0;
                underrun_q <= 1'b0;
            end
            if ((state == S_FETCH) && !fetch_done && empty) begin
                underrun_q <= 1'b1;
            end
            if (state == S_SETTLE) begin
                steps <= steps + 1'b1;
            end
        end
    end

    assign steps_done = steps;
    assign underrun   = underrun_q;
    assign dut_sw     = sw_q;
    assign stim_ready = !full;

`ifdef MOORE_CHECK_EN
    localparam int TN = 2 ** (ST_W + SW_W);

    logic [ST_W:0]           tbl [TN];
    logic [ST_W-1:0]         gold;
    logic                    mm_q;
    logic [CNT_W-1:0]        mm_step_q;
    logic [ST_W+SW_W-1:0]    idx;
    logic [ST_W-1:0]         exp_next;
    logic                    exp_out;
    logic                    differ;

    assign idx      = {gold, sw_q};
    assign exp_next = tbl[idx][ST_W:1];
    assign exp_out  = tbl[idx][0];
    assign differ   = (dut_state != exp_next) || (dut_out != exp_out);

    // Table survives controller reset so one configuration serves many runs
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl[cfg_addr] <= {cfg_next, cfg_out};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gold      <= '0;
            mm_q      <= 1'b0;
            mm_step_q <= '0;
        end else if (state == S_LOAD) begin
            gold      <= init_st;
            mm_q      <= 1'b0;
            mm_step_q <= '0;
        end else if (state == S_SETTLE) begin
            gold <= exp_next;
            if (differ && !mm_q) begin
                mm_q      <= 1'b1;
                mm_step_q <= steps + 1'b1;
            end
        end
    end

    assign mismatch      = mm_q;
    assign mismatch_step = mm_step_q;
`else
    logic unused_chk;
    assign unused_chk = ^{cfg_we, cfg_addr, cfg_next, cfg_out,
                          dut_state, dut_out};

    assign mismatch      = 1'b0;
    assign mismatch_step = '0;
`endif

endmodule
